jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

IEEE 1149.1-style TAP controller and instruction register for the s9234 test wrapper. It sits directly upstream of the s9234 boundary-scan wrapper and generates all of that wrapper's scan controls from TMS/TDI. It steers the boundary-scan chain or the internal-scan chain by the current instruction and multiplexes TDO_BSR, TDO_ISR or its own bypass bit onto TDO.

## Interface
- IR_W, 3: instruction register width
- TCLK  in  1  test clock; all state changes on rising edge
- TRST  in  1  synchronous active-low reset, sampled on TCLK rising edge
- TMS  in  1  test mode select
- TDI  in  1  serial test data in
- TDO_BSR  in  1  serial out of boundary-scan chain
- TDO_ISR  in  1  serial out of internal-scan chain
- clockdr, shiftdr, updatedr  out  1 each  boundary-scan chain controls
- clockdr_is, shiftdr_is, updatedr_is  out  1 each  internal-scan chain controls
- TDO  out  1  serial test data out
- tap_state  out  4  current TAP state encoding (debug/verification)
- ir  out  IR_W  active instruction

## Operation
- FSM: the 16 standard TAP states. Transitions:
  - TEST_LOGIC_RESET: TMS=0 → RUN_IDLE.
  - RUN_IDLE: TMS=1 → SELECT_DR.
  - SELECT_DR: 1 → SELECT_IR, 0 → CAPTURE_DR.
  - CAPTURE_DR: 1 → EXIT1_DR, 0 → SHIFT_DR.
  - SHIFT_DR: 1 → EXIT1_DR.
  - EXIT1_DR: 1 → UPDATE_DR, 0 → PAUSE_DR.
  - PAUSE_DR: 1 → EXIT2_DR.
  - EXIT2_DR: 1 → UPDATE_DR, 0 → SHIFT_DR.
  - UPDATE_DR: 1 → SELECT_DR, 0 → RUN_IDLE.
  - IR branch is identical.
  - SELECT_IR: TMS=1 → TEST_LOGIC_RESET.
  - Any unlisted TMS value holds the current state.
- Opcodes: EXTEST=000, SAMPLE=001, INTSCAN=010, BYPASS=111. All unlisted codes decode as BYPASS.
- DR select:
  - EXTEST/SAMPLE → boundary chain (no *_is control ever asserts).
  - INTSCAN → internal chain (no BSR control ever asserts).
  - BYPASS → 1-bit bypass register.
- For the selected chain:
  - shiftdr = 1 in SHIFT_DR.
  - clockdr = 1 in CAPTURE_DR or SHIFT_DR (clock-enable style, not a gated clock).
  - updatedr = 1 in UPDATE_DR.
  - All are 0 in every other state.
  - For SAMPLE, updatedr stays 0.
- IR shift register:
  - CAPTURE_IR loads 001.
  - SHIFT_IR shifts right: TDI enters the MSB, the LSB drives TDO.
  - UPDATE_IR copies the shift register into ir.
- Bypass bit:
  - CAPTURE_DR with BYPASS loads 0.
  - SHIFT_DR loads TDI.
- TDO is combinational from registers:
  - SHIFT_IR → ir_shift[0].
  - SHIFT_DR → selected chain's serial out (bypass bit, TDO_BSR or TDO_ISR).
  - Otherwise 0.
- In TEST_LOGIC_RESET, ir is forced to BYPASS every cycle.

## Timing
- TRST=0 at a rising edge gives, on the next cycle:
  - tap_state = TEST_LOGIC_RESET
  - ir = 111
  - ir_shift = 000
  - bypass = 0
  - all six controls = 0
  - TDO = 0
- Reset wins over any TMS value, including mid-shift; no partial IR update occurs.
- Five consecutive TMS=1 edges reach TEST_LOGIC_RESET from any state.
- Control outputs are decoded from the registered state. They assert in the same cycle tap_state shows the state, one edge after the TMS sample.
- A new ir takes effect the cycle after UPDATE_IR. Controls decoded in that UPDATE_IR cycle still use the old ir.
- PAUSE_DR/PAUSE_IR hold all shift registers; shiftdr and clockdr are 0.
- Bypass latency: TDI→TDO is exactly 1 TCLK.

## Structure
- Shared package jtag_pkg holds:
  - tap_state_t enum (4-bit, TEST_LOGIC_RESET=4'hF)
  - opcode localparams
  - IR capture constant 001
- Sub-module jtag_tap_fsm contains the state register and next-state logic only; it outputs tap_state.
- IR, bypass, control decode and TDO mux live in jtag_tap_ctrl. Total is about 200 lines.

## Test plan
- TRST=0 for 2 cycles, TMS random → tap_state=F, ir=111, all controls 0, TDO=0.
- Drive an arbitrary state, then TMS=1 ×5 → TEST_LOGIC_RESET on the fifth edge.
- IR scan shifting 000 (TMS 0,1,1,0,0, shift 3 bits, exit, update) → ir=000. TDO during the shift emits 1,0,0, the captured 001 LSB-first.
- EXTEST DR scan of 4 cycles:
  - clockdr is 1 for CAPTURE plus 4 shift cycles; shiftdr is 1 for 4 cycles.
  - TDO equals TDO_BSR during the shift.
  - updatedr pulses once; every *_is output stays 0.
- INTSCAN selected → only the *_is controls toggle, and TDO follows TDO_ISR.
- BYPASS with TDI pattern 1,0,1,1 in SHIFT_DR → TDO = 0,1,0,1.
- TRST=0 mid-SHIFT_IR after 2 bits → ir=111 and nothing updated.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the s9234 TAP controller.
// Contents: TAP state encoding (standard 1149.1 codes), instruction opcodes,
// the IR capture pattern, and a helper that maps an opcode to the data
// register chain it selects.
package jtag_pkg;

  localparam int IR_W = 3;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_EXTEST  = 3'b000;
  localparam logic [IR_W-1:0] OP_SAMPLE  = 3'b001;
  localparam logic [IR_W-1:0] OP_INTSCAN = 3'b010;
  localparam logic [IR_W-1:0] OP_BYPASS  = 3'b111;

  localparam logic [IR_W-1:0] IR_CAPTURE = 3'b001;

  typedef enum logic [1:0] {
    CHAIN_BSR,
    CHAIN_ISR,
    CHAIN_BYP
  } chain_t;

  // Unknown opcodes fall through to the bypass register.
  function automatic chain_t chain_of(input logic [IR_W-1:0] op);
    case (op)
      OP_EXTEST, OP_SAMPLE: chain_of = CHAIN_BSR;
      OP_INTSCAN:           chain_of = CHAIN_ISR;
      default:              chain_of = CHAIN_BYP;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Signal bundle between the test-access driver and the TAP controller.
//   TMS, TDI          : serial test inputs
//   TDO_BSR, TDO_ISR  : serial outputs of the boundary / internal scan chains
//   clockdr..updatedr : boundary-scan chain controls
//   *_is              : internal-scan chain controls
//   TDO               : serial test data out
//   tap_state, ir     : current TAP state and active instruction (debug)
// master = driver side, slave = TAP controller side.
interface jtag_tap_ctrl_if;

  logic                      TMS;
  logic                      TDI;
  logic                      TDO_BSR;
  logic                      TDO_ISR;
  logic                      clockdr;
  logic                      shiftdr;
  logic                      updatedr;
  logic                      clockdr_is;
  logic                      shiftdr_is;
  logic                      updatedr_is;
  logic                      TDO;
  logic [3:0]                tap_state;
  logic [jtag_pkg::IR_W-1:0] ir;

  modport master (
    output TMS, TDI, TDO_BSR, TDO_ISR,
    input  clockdr, shiftdr, updatedr, clockdr_is, shiftdr_is, updatedr_is,
    input  TDO, tap_state, ir
  );

  modport slave (
    input  TMS, TDI, TDO_BSR, TDO_ISR,
    output clockdr, shiftdr, updatedr, clockdr_is, shiftdr_is, updatedr_is,
    output TDO, tap_state, ir
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// TAP state register and next-state logic.
//   TCLK  : test clock
//   TRST  : synchronous active-low reset
//   tms   : test mode select
//   state : registered TAP state
//
// state            | meaning
// TEST_LOGIC_RESET | test logic idle, ir forced to BYPASS
// RUN_IDLE         | idle between scans
// SELECT_DR/IR     | branch choice: DR scan, IR scan, or back to reset
// CAPTURE_DR/IR    | load the selected register
// SHIFT_DR/IR      | shift TDI in, serial out on TDO
// EXIT1_DR/IR      | leave shift: update or pause
// PAUSE_DR/IR      | hold shift registers
// EXIT2_DR/IR      | leave pause: update or resume shift
// UPDATE_DR/IR     | commit shifted data
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       tms,
  output tap_state_t state
);

  always_ff @(posedge TCLK) begin
    if (!TRST) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      case (state)
        TEST_LOGIC_RESET: if (!tms) state <= RUN_IDLE;
        RUN_IDLE:         if (tms)  state <= SELECT_DR;
        SELECT_DR:        state <= tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       state <= tms ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:         if (tms)  state <= EXIT1_DR;
        EXIT1_DR:         state <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         if (tms)  state <= EXIT2_DR;
        EXIT2_DR:         state <= tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        state <= tms ? SELECT_DR : RUN_IDLE;
        SELECT_IR:        state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= tms ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:         if (tms)  state <= EXIT1_IR;
        EXIT1_IR:         state <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         if (tms)  state <= EXIT2_IR;
        EXIT2_IR:         state <= tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        state <= tms ? SELECT_DR : RUN_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller and instruction register for the s9234 test wrapper.
// Generates the boundary-scan and internal-scan chain controls from the TAP
// state and current instruction, holds the 1-bit bypass register, and
// multiplexes the selected serial output onto TDO.
//   TCLK : test clock, all state changes on the rising edge
//   TRST : synchronous active-low reset
//   jif  : slave side of jtag_tap_ctrl_if (TMS/TDI in, chain controls,
//          TDO, tap_state and ir out)
module jtag_tap_ctrl
  import jtag_pkg::*;
(
  input logic            TCLK,
  input logic            TRST,
  jtag_tap_ctrl_if.slave jif
);

  tap_state_t      state;
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] ir_shift;
  logic            bypass_q;
  chain_t          chain;
  logic            dr_clk_en;
  logic            dr_shift_en;
  logic            dr_update_en;
  logic            tdo_mux;

  jtag_tap_fsm u_fsm (
    .TCLK  (TCLK),
    .TRST  (TRST),
    .tms   (jif.TMS),
    .state (state)
  );

  assign chain = chain_of(ir_q);

  always_ff @(posedge TCLK) begin
    if (!TRST) begin
      ir_q     <= OP_BYPASS;
      ir_shift <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (state)
        CAPTURE_IR: ir_shift <= IR_CAPTURE;
        SHIFT_IR:   ir_shift <= {jif.TDI, ir_shift[IR_W-1:1]};
        default:    ;
      endcase

      if (state == TEST_LOGIC_RESET)
        ir_q <= OP_BYPASS;
      else if (state == UPDATE_IR)
        ir_q <= ir_shift;

      if (chain == CHAIN_BYP) begin
        if (state == CAPTURE_DR)
          bypass_q <= 1'b0;
        else if (state == SHIFT_DR)
          bypass_q <= jif.TDI;
      end
    end
  end

  // Chain-independent DR strobes, then steered to one chain by the opcode.
  always_comb begin
    dr_clk_en    = (state == CAPTURE_DR) || (state == SHIFT_DR);
    dr_shift_en  = (state == SHIFT_DR);
    dr_update_en = (state == UPDATE_DR);
  end

  always_comb begin
    jif.clockdr     = 1'b0;
    jif.shiftdr     = 1'b0;
    jif.updatedr    = 1'b0;
    jif.clockdr_is  = 1'b0;
    jif.shiftdr_is  = 1'b0;
    jif.updatedr_is = 1'b0;
    case (chain)
      CHAIN_BSR: begin
        jif.clockdr  = dr_clk_en;
        jif.shiftdr  = dr_shift_en;
        // SAMPLE only observes; the boundary outputs must not be updated.
        jif.updatedr = dr_update_en && (ir_q == OP_EXTEST);
      end
      CHAIN_ISR: begin
        jif.clockdr_is  = dr_clk_en;
        jif.shiftdr_is  = dr_shift_en;
        jif.updatedr_is = dr_update_en;
      end
      default: ;
    endcase
  end

  always_comb begin
    tdo_mux = 1'b0;
    if (state == SHIFT_IR) begin
      tdo_mux = ir_shift[0];
    end else if (state == SHIFT_DR) begin
      case (chain)
        CHAIN_BSR: tdo_mux = jif.TDO_BSR;
        CHAIN_ISR: tdo_mux = jif.TDO_ISR;
        default:   tdo_mux = bypass_q;
      endcase
    end
  end

  assign jif.TDO       = tdo_mux;
  assign jif.tap_state = state;
  assign jif.ir        = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: a table of per-edge vectors walking
// through IR and DR scans, plus hand sequences for reset and pause corners.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  logic TCLK = 1'b0;
  logic TRST = 1'b0;

  jtag_tap_ctrl_if jif ();

  jtag_tap_ctrl dut (
    .TCLK (TCLK),
    .TRST (TRST),
    .jif  (jif)
  );

  always #5 TCLK = ~TCLK;

  // Inputs applied before an edge, and the outputs expected just after it.
  // ctl order: clockdr shiftdr updatedr clockdr_is shiftdr_is updatedr_is
  typedef struct {
    int trst;
    int tms;
    int tdi;
    int bsr;
    int isr;
    int st;
    int ir;
    int ctl;
    int tdo;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input int trst, input int tms, input int tdi,
                              input int bsr, input int isr, input int st,
                              input int ir, input int ctl, input int tdo);
    vec_t v;
    v.trst = trst; v.tms = tms; v.tdi = tdi; v.bsr = bsr; v.isr = isr;
    v.st = st; v.ir = ir; v.ctl = ctl; v.tdo = tdo;
    vt.push_back(v);
  endfunction

  task automatic tick(input int tms, input int tdi);
    jif.TMS = 1'(tms);
    jif.TDI = 1'(tdi);
    @(posedge TCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] snap();
    return 16'({jif.tap_state, jif.ir, jif.clockdr, jif.shiftdr, jif.updatedr,
                jif.clockdr_is, jif.shiftdr_is, jif.updatedr_is, jif.TDO});
  endfunction

  task automatic ir_load(input logic [2:0] op);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 32'(op[0])); tick(0, 32'(op[1])); tick(1, 32'(op[2]));
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [15:0] exp;
    int n;

    jif.TMS = 1'b1; jif.TDI = 1'b0; jif.TDO_BSR = 1'b0; jif.TDO_ISR = 1'b0;

    //   trst tms tdi bsr isr  st    ir  ctl        tdo
    add(0, 1, 0, 0, 0, 'hF, 7, 'b000000, 0);  // reset
    add(0, 0, 0, 0, 0, 'hF, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hC, 7, 'b000000, 0);  // IR scan -> EXTEST
    add(1, 1, 0, 0, 0, 'h7, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h4, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hE, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hA, 7, 'b000000, 1);
    add(1, 0, 0, 0, 0, 'hA, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hA, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h9, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'hD, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hC, 0, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h7, 0, 'b000000, 0);  // EXTEST DR scan
    add(1, 0, 0, 0, 0, 'h6, 0, 'b100000, 0);
    add(1, 0, 0, 1, 0, 'h2, 0, 'b110000, 1);
    add(1, 0, 0, 0, 1, 'h2, 0, 'b110000, 0);
    add(1, 0, 0, 1, 0, 'h2, 0, 'b110000, 1);
    add(1, 0, 0, 0, 1, 'h2, 0, 'b110000, 0);
    add(1, 1, 0, 1, 0, 'h1, 0, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h5, 0, 'b001000, 0);
    add(1, 0, 0, 0, 0, 'hC, 0, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h7, 0, 'b000000, 0);  // IR scan -> INTSCAN
    add(1, 1, 0, 0, 0, 'h4, 0, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hE, 0, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hA, 0, 'b000000, 1);
    add(1, 0, 0, 0, 0, 'hA, 0, 'b000000, 0);
    add(1, 0, 1, 0, 0, 'hA, 0, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h9, 0, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'hD, 0, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hC, 2, 'b000000, 0);
    add(1, 1, 0, 1, 0, 'h7, 2, 'b000000, 0);  // INTSCAN DR scan
    add(1, 0, 0, 1, 0, 'h6, 2, 'b000100, 0);
    add(1, 0, 0, 0, 1, 'h2, 2, 'b000110, 1);
    add(1, 0, 0, 1, 0, 'h2, 2, 'b000110, 0);
    add(1, 1, 0, 0, 1, 'h1, 2, 'b000000, 0);
    add(1, 0, 0, 1, 1, 'h3, 2, 'b000000, 0);  // PAUSE_DR
    add(1, 1, 0, 1, 1, 'h0, 2, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h5, 2, 'b000001, 0);
    add(1, 0, 0, 0, 0, 'hC, 2, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h7, 2, 'b000000, 0);  // IR scan -> BYPASS
    add(1, 1, 0, 0, 0, 'h4, 2, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hE, 2, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hA, 2, 'b000000, 1);
    add(1, 0, 1, 0, 0, 'hA, 2, 'b000000, 0);
    add(1, 0, 1, 0, 0, 'hA, 2, 'b000000, 0);
    add(1, 1, 1, 0, 0, 'h9, 2, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'hD, 2, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hC, 7, 'b000000, 0);
    add(1, 1, 0, 1, 1, 'h7, 7, 'b000000, 0);  // BYPASS DR scan
    add(1, 0, 0, 1, 1, 'h6, 7, 'b000000, 0);
    add(1, 0, 1, 1, 1, 'h2, 7, 'b000000, 0);  // capture beats TDI
    add(1, 0, 1, 0, 0, 'h2, 7, 'b000000, 1);
    add(1, 0, 0, 1, 1, 'h2, 7, 'b000000, 0);
    add(1, 0, 1, 0, 0, 'h2, 7, 'b000000, 1);
    add(1, 1, 1, 0, 0, 'h1, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h5, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hC, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h7, 7, 'b000000, 0);  // IR scan -> SAMPLE
    add(1, 1, 0, 0, 0, 'h4, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hE, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hA, 7, 'b000000, 1);
    add(1, 0, 1, 0, 0, 'hA, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hA, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h9, 7, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'hD, 7, 'b000000, 0);
    add(1, 0, 0, 0, 0, 'hC, 1, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h7, 1, 'b000000, 0);  // SAMPLE DR, no update
    add(1, 0, 0, 0, 0, 'h6, 1, 'b100000, 0);
    add(1, 1, 0, 1, 0, 'h1, 1, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h5, 1, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h7, 1, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'h4, 1, 'b000000, 0);
    add(1, 1, 0, 0, 0, 'hF, 1, 'b000000, 0);  // ir forced on the next edge
    add(1, 1, 0, 0, 0, 'hF, 7, 'b000000, 0);

    foreach (vt[i]) begin
      TRST        = 1'(vt[i].trst);
      jif.TDO_BSR = 1'(vt[i].bsr);
      jif.TDO_ISR = 1'(vt[i].isr);
      tick(vt[i].tms, vt[i].tdi);
      exp = 16'({4'(vt[i].st), 3'(vt[i].ir), 6'(vt[i].ctl), 1'(vt[i].tdo)});
      chk($sformatf("vec%0d", i), snap(), exp);
    end
    jif.TDO_BSR = 1'b0;
    jif.TDO_ISR = 1'b0;

    // Reset from mid-SHIFT_DR with random TMS for two cycles.
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 1);
    TRST = 1'b0;
    tick(32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)));
    tick(32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)));
    chk("reset_mid_dr", snap(), 16'({4'hF, 3'b111, 6'b0, 1'b0}));
    TRST = 1'b1;

    // Five TMS=1 edges from arbitrary states.
    for (int k = 0; k < 6; k++) begin
      n = 32'($urandom_range(1, 12));
      for (int j = 0; j < n; j++)
        tick(32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)));
      for (int j = 0; j < 5; j++) tick(1, 0);
      chk($sformatf("tms5_%0d", k), 16'(jif.tap_state), 16'hF);
    end

    // Reset in the middle of an IR shift: no partial update.
    tick(0, 0);
    ir_load(3'b010);
    chk("ir_intscan", 16'(jif.ir), 16'h2);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 0); tick(0, 0);
    TRST = 1'b0;
    tick(1, 0);
    chk("reset_mid_ir", 16'({jif.tap_state, jif.ir}), 16'({4'hF, 3'b111}));
    TRST = 1'b1;
    tick(0, 0);
    chk("ir_after_reset", 16'({jif.tap_state, jif.ir}), 16'({4'hC, 3'b111}));

    // PAUSE_IR holds the IR shift register while TDI toggles.
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(1, 1);
    tick(0, 1); tick(0, 1); tick(0, 1);
    chk("pause_ir_tdo", 16'({jif.tap_state, jif.TDO}), 16'({4'hB, 1'b0}));
    tick(1, 1); tick(0, 1);
    chk("resume_ir_tdo", 16'({jif.tap_state, jif.TDO}), 16'({4'hA, 1'b0}));
    tick(1, 0); tick(1, 0); tick(0, 0);
    chk("pause_ir_result", 16'(jif.ir), 16'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
